row_scan_controller: RTL and testbench

Sequences one HUB75 row scan from the system clock. It divides `clk_in` into a gated pixel shift clock, emits column addresses for pixel fetch, and blanks the panel, latches the row and advances the row address. It sits between the frame buffer read port and the panel pins, replacing a free-running divided clock with a burst-gated, row-aware one.

---
 rtl/display_timing_pkg.sv | 34 +++
 rtl/clk_tick_gen.sv | 44 ++++
 rtl/row_scan_controller.sv | 175 +++++++++++++++++
 tb/tb_row_scan_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_timing_pkg.sv
// -----------------------------------------------------------------------------
// display_timing_pkg
// Shared definitions for the HUB75 row scan logic:
//   - scan state encoding (localparams plus the enum built from them)
//   - clog2 width helper used to size the column address
// -----------------------------------------------------------------------------
package display_timing_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_SHIFT = 3'd1;
   localparam logic [STATE_W-1:0] ST_BLANK = 3'd2;
   localparam logic [STATE_W-1:0] ST_LATCH = 3'd3;
   localparam logic [STATE_W-1:0] ST_SHOW  = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_BLANK = ST_BLANK,
      S_LATCH = ST_LATCH,
      S_SHOW  = ST_SHOW
   } scan_state_t;

   // Bits needed to hold 0..value-1; never less than 1 so a vector of this
   // width is always legal.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// -----------------------------------------------------------------------------
// clk_tick_gen
// Divides clk_in into a one-cycle tick every CLK_DIV_COUNT cycles while run is
// high. The count restarts from zero whenever run drops, so each burst of run
// produces its first tick exactly CLK_DIV_COUNT cycles after run rises.
//
// Ports:
//   clk_in  in   system clock
//   reset   in   synchronous, active-high
//   run     in   count enable; count is held at zero while low
//   tick    out  one-cycle pulse on the terminal count
// -----------------------------------------------------------------------------
module clk_tick_gen
   import display_timing_pkg::*;
#(
   parameter int CLK_DIV_COUNT = 5
) (
   input  logic clk_in,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int                CNT_W    = clog2(CLK_DIV_COUNT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV_COUNT - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_in) begin
      if (reset || !run) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Decoded from flops only; run comes from the controller's state register.
   assign tick = run && (cnt == CNT_LAST);

endmodule

// File: rtl/row_scan_controller.sv
// -----------------------------------------------------------------------------
// row_scan_controller
// Sequences one HUB75 row scan: shifts a row of pixels with a burst-gated
// pixel clock, blanks the panel, advances the row address, latches, then
// shows the row for one cycle before starting the next.
//
// Ports:
//   clk_in       in   system clock, rising edge
//   reset        in   synchronous, active-high
//   enable       in   run request, honoured only in IDLE and SHOW
//   pixel_clk    out  panel shift clock, toggles only while shifting
//   col_addr     out  column whose data must be valid at next pixel_clk rise
//   row_addr     out  panel row select
//   latch        out  panel latch strobe
//   oe_n         out  panel output enable, active-low
//   row_done     out  one-cycle pulse per completed row
//   frame_start  out  one-cycle pulse with row_done when row_addr is 0
// All outputs are registered.
// -----------------------------------------------------------------------------
module row_scan_controller
   import display_timing_pkg::*;
#(
   parameter int CLK_DIV_COUNT  = 5,
   parameter int PIXELS_PER_ROW = 64,
   parameter int ROW_ADDR_WIDTH = 4,
   parameter int BLANK_CYCLES   = 4,
   parameter int LATCH_CYCLES   = 2
) (
   input  logic                               clk_in,
   input  logic                               reset,
   input  logic                               enable,
   output logic                               pixel_clk,
   output logic [clog2(PIXELS_PER_ROW)-1:0]   col_addr,
   output logic [ROW_ADDR_WIDTH-1:0]          row_addr,
   output logic                               latch,
   output logic                               oe_n,
   output logic                               row_done,
   output logic                               frame_start
);

   localparam int COL_W     = clog2(PIXELS_PER_ROW);
   localparam int PHASE_MAX = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
   localparam int PHASE_W   = clog2(PHASE_MAX);

   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(PIXELS_PER_ROW - 1);
   localparam logic [PHASE_W-1:0] BLANK_LAST = PHASE_W'(BLANK_CYCLES - 1);
   localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
   // Phase count of the cycle before the final blank cycle.
   localparam logic [PHASE_W-1:0] BLANK_PRE  =
      (BLANK_CYCLES >= 2) ? PHASE_W'(BLANK_CYCLES - 2) : '0;

   scan_state_t          state;
   logic [PHASE_W-1:0]   phase_cnt;
   logic                 shift_run;
   logic                 tick;
   logic                 shift_last;
   logic                 row_step;

   assign shift_run = (state == S_SHIFT);

   clk_tick_gen #(
      .CLK_DIV_COUNT (CLK_DIV_COUNT)
   ) u_tick (
      .clk_in (clk_in),
      .reset  (reset),
      .run    (shift_run),
      .tick   (tick)
   );

   // Falling pixel_clk toggle on the last column ends the shift burst.
   assign shift_last = shift_run && tick && pixel_clk && (col_addr == COL_LAST);

   // The row address moves on entry to the final blank cycle, so it settles
   // while the panel is dark and at least one cycle ahead of the latch rise.
   // With a single blank cycle that entry is the shift-to-blank edge itself.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      row_step = 1'b0;
      if (BLANK_CYCLES == 1) begin
         row_step = shift_last;
      end else begin
         row_step = (state == S_BLANK) && (phase_cnt == BLANK_PRE);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state       <= S_IDLE;
         phase_cnt   <= '0;
         pixel_clk   <= 1'b0;
         col_addr    <= '0;
         row_addr    <= '0;
         latch       <= 1'b0;
         oe_n        <= 1'b1;
         row_done    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         row_done    <= 1'b0;
         frame_start <= 1'b0;

         if (row_step) begin
            row_addr <= row_addr + 1'b1;
         end

         case (state)
            S_IDLE: begin
               oe_n      <= 1'b1;
               pixel_clk <= 1'b0;
               if (enable) begin
                  state    <= S_SHIFT;
                  col_addr <= '0;
               end
            end

            // oe_n is left alone so the previous row stays lit while the
            // next one shifts in.
            S_SHIFT: begin
               if (tick) begin
                  if (pixel_clk) begin
                     pixel_clk <= 1'b0;
                     if (col_addr == COL_LAST) begin
                        col_addr  <= '0;
                        oe_n      <= 1'b1;
                        phase_cnt <= '0;
                        state     <= S_BLANK;
                     end else begin
                        col_addr <= col_addr + 1'b1;
                     end
                  end else begin
                     pixel_clk <= 1'b1;
                  end
               end
            end

            S_BLANK: begin
               if (phase_cnt == BLANK_LAST) begin
                  phase_cnt <= '0;
                  latch     <= 1'b1;
                  state     <= S_LATCH;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end

            S_LATCH: begin
               if (phase_cnt == LATCH_LAST) begin
                  phase_cnt   <= '0;
                  latch       <= 1'b0;
                  oe_n        <= 1'b0;
                  row_done    <= 1'b1;
                  frame_start <= (row_addr == '0);
                  state       <= S_SHOW;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end

            S_SHOW: begin
               if (enable) begin
                  state <= S_SHIFT;
               end else begin
                  oe_n  <= 1'b1;
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_row_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_row_scan_controller
// Two instances share enable/reset: cfg0 divides by 2, cfg1 by 1; both use
// 4 pixels, 4 rows, 2 blank cycles and 1 latch cycle. For each run request
// the bench predicts, from row-period arithmetic, every pixel_clk rise and
// every row completion, queues them, and a per-instance monitor pops and
// compares as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_row_scan_controller;

   localparam int P      = 4;
   localparam int R      = 2;
   localparam int B      = 2;
   localparam int L      = 1;
   localparam int ROWS   = 1 << R;
   localparam int COL_W  = 2;
   localparam int SETTLE = 26;
   localparam int NO_CUT = 32'h3fff_ffff;

   typedef struct {
      int cyc;
      int col;
   } rise_t;

   typedef struct {
      int show;
      int row;
      bit frame;
      int oe_rise;
      int start;
   } row_t;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   logic enable = 1'b0;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   int   plan_en;
   int   plan_drop;
   int   plan_cut;
   bit   plan_rst;
   event plan_ev;
   event rst_chk_ev;
   event drain_ev;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int D = (g == 0) ? 2 : 1;
      localparam int T = 2 * D * P + B + L + 1;

      logic             pixel_clk;
      logic [COL_W-1:0] col_addr;
      logic [R-1:0]     row_addr;
      logic             latch;
      logic             oe_n;
      logic             row_done;
      logic             frame_start;

      rise_t rise_q[$];
      row_t  row_q[$];
      int    rc = 0;

      logic         prev_pclk;
      logic         prev_latch;
      logic         prev_oe;
      logic         prev_rst;
      logic [R-1:0] prev_row;
      int           last_oe_rise    = -1000;
      int           last_latch_rise = -1000;

      row_scan_controller #(
         .CLK_DIV_COUNT  (D),
         .PIXELS_PER_ROW (P),
         .ROW_ADDR_WIDTH (R),
         .BLANK_CYCLES   (B),
         .LATCH_CYCLES   (L)
      ) u_dut (
         .clk_in      (clk_in),
         .reset       (reset),
         .enable      (enable),
         .pixel_clk   (pixel_clk),
         .col_addr    (col_addr),
         .row_addr    (row_addr),
         .latch       (latch),
         .oe_n        (oe_n),
         .row_done    (row_done),
         .frame_start (frame_start)
      );

      // Reference model: row k of a burst starts at plan_en+1+k*T; it has P
      // rises 2*D apart starting D cycles in, and shows in its last cycle.
      // The next row follows only if enable is still high in that show cycle.
      always @(plan_ev) begin : planner
         int    k;
         int    s;
         int    show;
         int    c;
         bit    go;
         rise_t er;
         row_t  ex;
         k  = 0;
         go = 1'b1;
         while (go) begin
            s = plan_en + 1 + k * T;
            if (s > plan_cut) begin
               go = 1'b0;
            end else begin
               for (int j = 0; j < P; j++) begin
                  c = s + D + 2 * D * j;
                  if (c <= plan_cut) begin
                     er.cyc = c;
                     er.col = j;
                     rise_q.push_back(er);
                  end
               end
               show = s + T - 1;
               if (show <= plan_cut) begin
                  rc         = rc + 1;
                  ex.show    = show;
                  ex.row     = rc % ROWS;
                  ex.frame   = ((rc % ROWS) == 0);
                  ex.oe_rise = (k > 0) ? s + 2 * D * P : -1;
                  ex.start   = s;
                  row_q.push_back(ex);
               end
               if (show >= plan_drop || show >= plan_cut) go = 1'b0;
               k++;
            end
         end
         if (plan_rst) rc = 0;
      end

      always @(negedge clk_in) begin : monitor
         rise_t er;
         row_t  ex;
         if (mon_en) begin
            if (pixel_clk === 1'b1 && prev_pclk === 1'b0) begin
               if (rise_q.size() == 0) begin
                  check(1'b0, $sformatf("cfg%0d unexpected pixel_clk rise", g), cyc, -1);
               end else begin
                  er = rise_q.pop_front();
                  check(cyc == er.cyc, $sformatf("cfg%0d rise cycle", g), cyc, er.cyc);
                  check(int'(col_addr) == er.col, $sformatf("cfg%0d col_addr at rise", g),
                        int'(col_addr), er.col);
               end
            end

            if (row_addr !== prev_row && prev_rst !== 1'b1) begin
               check(oe_n === 1'b1 && prev_oe === 1'b1,
                     $sformatf("cfg%0d row_addr change with oe_n low", g), int'(oe_n), 1);
            end

            if (frame_start === 1'b1) begin
               check(row_done === 1'b1, $sformatf("cfg%0d frame_start without row_done", g),
                     int'(row_done), 1);
            end

            if (row_done === 1'b1) begin
               if (row_q.size() == 0) begin
                  check(1'b0, $sformatf("cfg%0d unexpected row_done", g), cyc, -1);
               end else begin
                  ex = row_q.pop_front();
                  check(cyc == ex.show, $sformatf("cfg%0d row_done cycle", g), cyc, ex.show);
                  check(int'(row_addr) == ex.row, $sformatf("cfg%0d row_addr", g),
                        int'(row_addr), ex.row);
                  check(frame_start === ex.frame, $sformatf("cfg%0d frame_start", g),
                        int'(frame_start), int'(ex.frame));
                  check(last_latch_rise == ex.show - L, $sformatf("cfg%0d latch rise cycle", g),
                        last_latch_rise, ex.show - L);
                  check(latch === 1'b0 && prev_latch === 1'b1,
                        $sformatf("cfg%0d latch falls into show", g), int'(latch), 0);
                  check(oe_n === 1'b0 && prev_oe === 1'b1,
                        $sformatf("cfg%0d oe_n falls into show", g), int'(oe_n), 0);
                  if (ex.oe_rise >= 0) begin
                     check(last_oe_rise == ex.oe_rise, $sformatf("cfg%0d oe_n rise cycle", g),
                           last_oe_rise, ex.oe_rise);
                  end else begin
                     check(last_oe_rise < ex.start, $sformatf("cfg%0d oe_n dark before row", g),
                           last_oe_rise, ex.start);
                  end
               end
            end

            if (oe_n === 1'b1 && prev_oe === 1'b0) last_oe_rise <= cyc;
            if (latch === 1'b1 && prev_latch === 1'b0) last_latch_rise <= cyc;
         end
         prev_pclk  <= pixel_clk;
         prev_latch <= latch;
         prev_oe    <= oe_n;
         prev_row   <= row_addr;
         prev_rst   <= reset;
      end

      always @(rst_chk_ev) begin
         check(pixel_clk === 1'b0, $sformatf("cfg%0d reset pixel_clk", g), int'(pixel_clk), 0);
         check(col_addr === '0, $sformatf("cfg%0d reset col_addr", g), int'(col_addr), 0);
         check(row_addr === '0, $sformatf("cfg%0d reset row_addr", g), int'(row_addr), 0);
         check(latch === 1'b0, $sformatf("cfg%0d reset latch", g), int'(latch), 0);
         check(oe_n === 1'b1, $sformatf("cfg%0d reset oe_n", g), int'(oe_n), 1);
         check(row_done === 1'b0, $sformatf("cfg%0d reset row_done", g), int'(row_done), 0);
         check(frame_start === 1'b0, $sformatf("cfg%0d reset frame_start", g),
               int'(frame_start), 0);
      end

      always @(drain_ev) begin
         check(rise_q.size() == 0, $sformatf("cfg%0d missing pixel_clk rises", g),
               rise_q.size(), 0);
         check(row_q.size() == 0, $sformatf("cfg%0d missing row_done", g), row_q.size(), 0);
         check(oe_n === 1'b1, $sformatf("cfg%0d idle oe_n", g), int'(oe_n), 1);
         check(pixel_clk === 1'b0, $sformatf("cfg%0d idle pixel_clk", g), int'(pixel_clk), 0);
      end
   end

   // Raise enable for one burst of `hold` cycles, optionally ending it with a
   // one-cycle reset, then let both instances run out and drain.
   task automatic run_plan(input int hold, input bit do_rst);
      int n0;
      @(posedge clk_in);
      #1;
      n0        = cyc;
      plan_en   = n0;
      plan_drop = n0 + hold;
      plan_rst  = do_rst;
      plan_cut  = do_rst ? n0 + hold : NO_CUT;
      -> plan_ev;
      enable = 1'b1;
      repeat (hold) @(posedge clk_in);
      #1;
      enable = 1'b0;
      if (do_rst) begin
         reset = 1'b1;
         @(posedge clk_in);
         #1;
         -> rst_chk_ev;
         reset = 1'b0;
      end
      repeat (SETTLE) @(posedge clk_in);
      #1;
      -> drain_ev;
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      -> rst_chk_ev;
      reset  = 1'b0;
      mon_en = 1'b1;

      run_plan(6, 1'b0);    // enable dropped five cycles into the first row
      run_plan(78, 1'b0);   // four full rows for cfg0, frame wrap
      run_plan(4, 1'b1);    // reset mid-shift
      run_plan(30, 1'b0);   // restart after reset
      for (int i = 0; i < 10; i++) begin
         run_plan(int'($urandom_range(1, 90)), ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(posedge clk_in);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
